// File: rtl/gecko_boot_sequencer.sv
// gecko_boot_sequencer
//   Loads a program image into memory over AXI4, one single-beat write per
//   32-bit word, then releases the gecko_compute core from reset and watches
//   its status flags until it finishes or faults.
//
//   Optional feature: define GECKO_BOOT_VERIFY_EN to read back every written
//   word over the AXI read channel and compare it with what was written.
//   Without it the read channel is idle (arvalid=0, rready=1).
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start, length       begin a load/run; length = word count (0 = run only)
//   prog_*              program word stream (valid/ready)
//   axi_aw*/w*/b*       AXI4 write master, one outstanding single-beat write
//   axi_ar*/r*          AXI4 read master (verify only)
//   core_rst            reset to the core, released only in RUN and DONE
//   faulted_flag,
//   finished_flag       core status
//   busy, done, error,
//   error_code          sequencer status (1 bresp, 2 verify, 3 core fault)
module gecko_boot_sequencer #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    ID_WIDTH    = 1,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR  = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic                   prog_valid,
    output logic                   prog_ready,
    input  logic [31:0]            prog_data,
    output logic                   axi_awvalid,
    input  logic                   axi_awready,
    output logic [ADDR_WIDTH-1:0]  axi_awaddr,
    output logic [ID_WIDTH-1:0]    axi_awid,
    output logic [7:0]             axi_awlen,
    output logic [2:0]             axi_awsize,
    output logic [1:0]             axi_awburst,
    output logic                   axi_wvalid,
    input  logic                   axi_wready,
    output logic [31:0]            axi_wdata,
    output logic [3:0]             axi_wstrb,
    output logic                   axi_wlast,
    input  logic                   axi_bvalid,
    output logic                   axi_bready,
    input  logic [1:0]             axi_bresp,
    input  logic [ID_WIDTH-1:0]    axi_bid,
    output logic                   axi_arvalid,
    input  logic                   axi_arready,
    output logic [ADDR_WIDTH-1:0]  axi_araddr,
    output logic [ID_WIDTH-1:0]    axi_arid,
    input  logic                   axi_rvalid,
    output logic                   axi_rready,
    input  logic [31:0]            axi_rdata,
    input  logic [1:0]             axi_rresp,
    output logic                   core_rst,
    input  logic                   faulted_flag,
    input  logic                   finished_flag,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             error_code
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WRITE,
        RESP,
`ifdef GECKO_BOOT_VERIFY_EN
        VERIFY_AR,
        VERIFY_R,
`endif
        RUN,
        DONE,
        ERROR
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH-1:0] len_q, len_d;
    logic [31:0]            word_q, word_d;
    logic                   awv_q, awv_d;
    logic                   wv_q, wv_d;
    logic                   bready_q, bready_d;
    logic [1:0]             err_q, err_d;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [COUNT_WIDTH:0]   idx_inc;
    logic                   last_word;

    // One extra bit so index+1 cannot wrap before the compare.
    assign idx_inc   = {1'b0, idx_q} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign last_word = (idx_inc == {1'b0, len_q});
    assign addr      = START_ADDR + (ADDR_WIDTH'(idx_q) << 2);

`ifdef GECKO_BOOT_VERIFY_EN
    logic arv_q, arv_d;
    logic rready_q, rready_d;
    logic unused;
    assign unused = ^axi_bid;
`else
    logic unused;
    assign unused = ^{axi_bid, axi_arready, axi_rvalid, axi_rdata, axi_rresp};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            word_q   <= '0;
            awv_q    <= 1'b0;
            wv_q     <= 1'b0;
            bready_q <= 1'b0;
            err_q    <= 2'd0;
`ifdef GECKO_BOOT_VERIFY_EN
            arv_q    <= 1'b0;
            rready_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            word_q   <= word_d;
            awv_q    <= awv_d;
            wv_q     <= wv_d;
            bready_q <= bready_d;
            err_q    <= err_d;
`ifdef GECKO_BOOT_VERIFY_EN
            arv_q    <= arv_d;
            rready_q <= rready_d;
`endif
        end
    end

    // Next-state logic also computes the next value of every AXI valid/ready
    // so that those outputs come straight from flops.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        word_d   = word_q;
        awv_d    = awv_q;
        wv_d     = wv_q;
        bready_d = bready_q;
        err_d    = err_q;
`ifdef GECKO_BOOT_VERIFY_EN
        arv_d    = arv_q;
        rready_d = rready_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    len_d   = length;
                    idx_d   = '0;
                    err_d   = 2'd0;
                    state_d = (length == '0) ? RUN : FETCH;
                end
            end
            FETCH: begin
                if (prog_valid) begin
                    word_d  = prog_data;
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Address and data channels complete independently.
                if (awv_q && axi_awready) awv_d = 1'b0;
                if (wv_q && axi_wready)   wv_d  = 1'b0;
                if ((!awv_q || axi_awready) && (!wv_q || axi_wready)) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (axi_bvalid) begin
                    bready_d = 1'b0;
                    if (axi_bresp != 2'b00) begin
                        err_d   = 2'd1;
                        state_d = ERROR;
                    end else begin
`ifdef GECKO_BOOT_VERIFY_EN
                        arv_d   = 1'b1;
                        state_d = VERIFY_AR;
`else
                        idx_d   = idx_inc[COUNT_WIDTH-1:0];
                        state_d = last_word ? RUN : FETCH;
`endif
                    end
                end
            end
`ifdef GECKO_BOOT_VERIFY_EN
            VERIFY_AR: begin
                if (axi_arready) begin
                    arv_d    = 1'b0;
                    rready_d = 1'b1;
                    state_d  = VERIFY_R;
                end
            end
            VERIFY_R: begin
                if (axi_rvalid) begin
                    rready_d = 1'b0;
                    if (axi_rresp != 2'b00 || axi_rdata != word_q) begin
                        err_d   = 2'd2;
                        state_d = ERROR;
                    end else begin
                        idx_d   = idx_inc[COUNT_WIDTH-1:0];
                        state_d = last_word ? RUN : FETCH;
                    end
                end
            end
`endif
            RUN: begin
                // A fault outranks a simultaneous finish.
                if (faulted_flag) begin
                    err_d   = 2'd3;
                    state_d = ERROR;
                end else if (finished_flag) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign prog_ready  = (state_q == FETCH);
    assign axi_awvalid = awv_q;
    assign axi_awaddr  = addr;
    assign axi_awid    = '0;
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = 3'd2;
    assign axi_awburst = 2'b01;
    assign axi_wvalid  = wv_q;
    assign axi_wdata   = word_q;
    assign axi_wstrb   = 4'hF;
    assign axi_wlast   = 1'b1;
    assign axi_bready  = bready_q;
    assign axi_araddr  = addr;
    assign axi_arid    = '0;
`ifdef GECKO_BOOT_VERIFY_EN
    assign axi_arvalid = arv_q;
    assign axi_rready  = rready_q;
`else
    assign axi_arvalid = 1'b0;
    assign axi_rready  = 1'b1;
`endif

    assign core_rst   = !(state_q == RUN || state_q == DONE);
    assign busy       = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign error_code = err_q;

endmodule
